dcp_loader: RTL



---
 rtl/dcp_loader_if.sv | 32 +++
 rtl/dcp_loader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dcp_loader_if.sv
// Handshake and memory-write bundle between dcp_loader and its surroundings
// (dispatcher, rx/tx handshake units, debug memory write ports).
interface dcp_loader_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned N_MEM  = 2
);
  logic [7:0]        sel_mode;
  logic              finish;
  logic              req_rx;
  logic              type_rx;
  logic              ack_rx;
  logic              flag_rx;
  logic [DATA_W-1:0] din_rx;
  logic              req_tx;
  logic              ack_tx;
  logic [7:0]        dout_tx;
  logic [N_MEM-1:0]  mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [ADDR_W:0]   word_cnt;

  modport master (
    input  sel_mode, ack_rx, flag_rx, din_rx, ack_tx,
    output finish, req_rx, type_rx, req_tx, dout_tx, mem_we, mem_addr, mem_data, word_cnt
  );

  modport slave (
    output sel_mode, ack_rx, flag_rx, din_rx, ack_tx,
    input  finish, req_rx, type_rx, req_tx, dout_tx, mem_we, mem_addr, mem_data, word_cnt
  );
endinterface

// File: rtl/dcp_loader.sv
// LOAD command engine: target-select byte + word stream -> sequential memory writes -> status string.
// Define DCP_LOADER_CKSUM_EN to append a modulo-256 byte checksum (two hex digits) to "FINISH".
module dcp_loader #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned N_MEM      = 2,
  parameter int unsigned NULL_LIMIT = 3,
  parameter logic [7:0]  CMD_CODE   = 8'h4C
) (
  input logic          clk,
  input logic          rst,
  dcp_loader_if.master dcp
);
  localparam logic [ADDR_W:0] L_DEPTH = {1'b1, {ADDR_W{1'b0}}};
`ifdef DCP_LOADER_CKSUM_EN
  localparam logic [3:0] L_FIN_LAST = 4'd10;
`else
  localparam logic [3:0] L_FIN_LAST = 4'd7;
`endif

  typedef enum logic [2:0] {S_IDLE, S_SEL, S_DATA, S_WRITE, S_MSG, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_armed, w_armed_nxt;
  logic [3:0]        r_tgt, w_tgt_nxt;
  logic [ADDR_W:0]   r_wcnt, w_wcnt_nxt;
  logic [7:0]        r_nulls, w_nulls_nxt;
  logic [3:0]        r_idx, w_idx_nxt;
  logic              r_err, w_err_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_data, w_data_nxt;
  logic [N_MEM-1:0]  r_we, w_we_nxt;
  logic              r_req_rx, w_req_rx_nxt;
  logic              r_req_tx, w_req_tx_nxt;
  logic [7:0]        r_dout, w_dout_nxt;
  logic [7:0]        w_msg_byte;
  logic [7:0]        w_sel_off;
  logic              w_en, w_rx_acc, w_tx_acc, w_sel_ok;

  assign w_en      = (dcp.sel_mode == CMD_CODE);
  assign w_rx_acc  = r_req_rx & dcp.ack_rx;
  assign w_tx_acc  = r_req_tx & dcp.ack_tx;
  assign w_sel_off = dcp.din_rx[7:0] - 8'h30;
  assign w_sel_ok  = (dcp.din_rx[7:0] >= 8'h30) && (w_sel_off < 8'(N_MEM));

`ifdef DCP_LOADER_CKSUM_EN
  logic [7:0] r_sum, w_sum_nxt;

  function automatic logic [7:0] hex_char(input logic [3:0] d);
    return (d < 4'd10) ? (8'h30 + {4'h0, d}) : (8'h37 + {4'h0, d});
  endfunction

  always_comb begin
    w_sum_nxt = r_sum;
    if (r_state == S_IDLE) begin
      w_sum_nxt = '0;
    end else if (r_state == S_WRITE && w_en) begin
      for (int unsigned k = 0; k < DATA_W / 8; k++) begin
        w_sum_nxt = w_sum_nxt + r_data[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sum <= '0;
    else     r_sum <= w_sum_nxt;
  end
`endif

  always_comb begin
    w_msg_byte = 8'h00;
    if (r_err) begin
      case (r_idx)
        4'd0:       w_msg_byte = "E";
        4'd1, 4'd2: w_msg_byte = "R";
        4'd3:       w_msg_byte = 8'h0D;
        4'd4:       w_msg_byte = 8'h0A;
        default:    ;
      endcase
    end else begin
      case (r_idx)
        4'd0:       w_msg_byte = "F";
        4'd1, 4'd3: w_msg_byte = "I";
        4'd2:       w_msg_byte = "N";
        4'd4:       w_msg_byte = "S";
        4'd5:       w_msg_byte = "H";
`ifdef DCP_LOADER_CKSUM_EN
        4'd6:       w_msg_byte = " ";
        4'd7:       w_msg_byte = hex_char(r_sum[7:4]);
        4'd8:       w_msg_byte = hex_char(r_sum[3:0]);
        4'd9:       w_msg_byte = 8'h0D;
        4'd10:      w_msg_byte = 8'h0A;
`else
        4'd6:       w_msg_byte = 8'h0D;
        4'd7:       w_msg_byte = 8'h0A;
`endif
        default:    ;
      endcase
    end
  end

  // Requests are registered and drop at the accepting edge, so each handshake
  // leaves at least one idle request cycle before the next one.
  always_comb begin
    w_state_nxt  = r_state;
    w_armed_nxt  = r_armed;
    w_tgt_nxt    = r_tgt;
    w_wcnt_nxt   = r_wcnt;
    w_nulls_nxt  = r_nulls;
    w_idx_nxt    = r_idx;
    w_err_nxt    = r_err;
    w_addr_nxt   = r_addr;
    w_data_nxt   = r_data;
    w_we_nxt     = '0;
    w_req_rx_nxt = 1'b0;
    w_req_tx_nxt = 1'b0;
    w_dout_nxt   = r_dout;

    if (!w_en) begin
      w_state_nxt = S_IDLE;
      w_armed_nxt = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_wcnt_nxt  = '0;
          w_nulls_nxt = '0;
          w_idx_nxt   = '0;
          if (r_armed) w_state_nxt = S_SEL;
        end
        S_SEL: begin
          if (w_rx_acc) begin
            if (!dcp.flag_rx && w_sel_ok) begin
              w_tgt_nxt   = w_sel_off[3:0];
              w_state_nxt = S_DATA;
            end else begin
              w_err_nxt   = 1'b1;
              w_state_nxt = S_MSG;
            end
          end else begin
            w_req_rx_nxt = 1'b1;
          end
        end
        S_DATA: begin
          if (w_rx_acc) begin
            if (!dcp.flag_rx) begin
              w_data_nxt  = dcp.din_rx;
              w_addr_nxt  = r_wcnt[ADDR_W-1:0];
              w_nulls_nxt = '0;
              for (int unsigned i = 0; i < N_MEM; i++) begin
                if (r_tgt == 4'(i)) w_we_nxt[i] = 1'b1;
              end
              w_state_nxt = S_WRITE;
            end else if (r_nulls + 8'd1 == 8'(NULL_LIMIT)) begin
              w_err_nxt   = 1'b0;
              w_state_nxt = S_MSG;
            end else begin
              w_nulls_nxt = r_nulls + 8'd1;
            end
          end else begin
            w_req_rx_nxt = 1'b1;
          end
        end
        S_WRITE: begin
          w_wcnt_nxt = r_wcnt + 1'b1;
          if (w_wcnt_nxt == L_DEPTH) begin
            w_err_nxt   = 1'b0;
            w_state_nxt = S_MSG;
          end else begin
            w_req_rx_nxt = 1'b1;
            w_state_nxt  = S_DATA;
          end
        end
        S_MSG: begin
          if (w_tx_acc) begin
            if (r_idx == (r_err ? 4'd4 : L_FIN_LAST)) w_state_nxt = S_DONE;
            else                                      w_idx_nxt   = r_idx + 4'd1;
          end else begin
            w_req_tx_nxt = 1'b1;
            w_dout_nxt   = w_msg_byte;
          end
        end
        S_DONE: begin
          w_armed_nxt = 1'b0;
          w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_armed  <= 1'b1;
      r_tgt    <= '0;
      r_wcnt   <= '0;
      r_nulls  <= '0;
      r_idx    <= '0;
      r_err    <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_we     <= '0;
      r_req_rx <= 1'b0;
      r_req_tx <= 1'b0;
      r_dout   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_armed  <= w_armed_nxt;
      r_tgt    <= w_tgt_nxt;
      r_wcnt   <= w_wcnt_nxt;
      r_nulls  <= w_nulls_nxt;
      r_idx    <= w_idx_nxt;
      r_err    <= w_err_nxt;
      r_addr   <= w_addr_nxt;
      r_data   <= w_data_nxt;
      r_we     <= w_we_nxt;
      r_req_rx <= w_req_rx_nxt;
      r_req_tx <= w_req_tx_nxt;
      r_dout   <= w_dout_nxt;
    end
  end

  assign dcp.finish   = (r_state == S_DONE);
  assign dcp.req_rx   = r_req_rx & ~dcp.ack_rx;
  assign dcp.type_rx  = (r_state == S_DATA);
  assign dcp.req_tx   = r_req_tx & ~dcp.ack_tx;
  assign dcp.dout_tx  = r_dout;
  assign dcp.mem_we   = r_we;
  assign dcp.mem_addr = r_addr;
  assign dcp.mem_data = r_data;
  assign dcp.word_cnt = r_wcnt;
endmodule
